// File: rtl/muldiv_unit_if.sv
// Core-side bundle for the HI/LO multiply/divide unit.
// Carries launch, MTHI/MTLO writes and the HI/LO read-back.
interface muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    output hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave m
);
  localparam int W  = DATA_W;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc, acc_step;
  logic [2*W-1:0]  a_q, a_step;
  logic [W-1:0]    b_q, b_step;
  logic [W-1:0]    hi_q, lo_q;
  logic [W-1:0]    hi_fix, lo_fix;
  logic            is_div, neg_q, neg_r;
  logic            done_q;

  logic            sgn, sa, sb;
  logic [W-1:0]    mag_a, mag_b;
  logic            fast_go;
  logic [2*W-1:0]  start_acc;
  logic [W:0]      trial, diff;
  logic            fits;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]  fast_prod;
  assign fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
  assign fast_go   = ~m.op[1];
  assign start_acc = fast_go ? fast_prod : '0;
`else
  assign fast_go   = 1'b0;
  assign start_acc = '0;
`endif

  always_comb begin
    sgn   = ~m.op[0];
    sa    = sgn & m.rs_val[W-1];
    sb    = sgn & m.rt_val[W-1];
    mag_a = sa ? -m.rs_val : m.rs_val;
    mag_b = sb ? -m.rt_val : m.rt_val;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (m.start) state_n = fast_go ? FIX : RUN;
      RUN:  if (cnt == CW'(DATA_W - 1)) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One step: shift-add for multiply, restoring trial subtract for divide
  always_comb begin
    trial  = {acc[2*W-1:W], a_q[W-1]};
    diff   = trial - {1'b0, b_q};
    fits   = trial >= {1'b0, b_q};
    a_step = a_q << 1;
    if (is_div) begin
      acc_step = {fits ? diff[W-1:0] : trial[W-1:0],
                  acc[W-2:0], fits};
      b_step   = b_q;
    end else begin
      acc_step = acc + (b_q[0] ? a_q : '0);
      b_step   = b_q >> 1;
    end
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = acc[W-1:0];
    rem  = acc[2*W-1:W];
    if (is_div) begin
      lo_fix = (b_q == '0) ? '1 : (neg_q ? -quo : quo);
      hi_fix = neg_r ? -rem : rem;
    end else begin
      hi_fix = prod[2*W-1:W];
      lo_fix = prod[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m.start) begin
            is_div <= m.op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            a_q    <= {{W{1'b0}}, mag_a};
            b_q    <= mag_b;
            acc    <= start_acc;
            cnt    <= '0;
          end else begin
            if (m.hi_we) hi_q <= m.wdata;
            if (m.lo_we) lo_q <= m.wdata;
          end
        end
        RUN: begin
          acc <= acc_step;
          a_q <= a_step;
          b_q <= b_step;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi_q   <= hi_fix;
          lo_q   <= lo_fix;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m.busy = (state != IDLE);
  assign m.done = done_q;
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_W(32)) bus ();

  muldiv_unit #(.DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .m    (bus)
  );

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin q = sa * sb; return q; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; return u; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return 33;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [63:0] exp;
    logic [31:0] h0, l0;
    int lat, bcnt;
    bit held, seen;
    exp = model(o, a, b);
    @(negedge clk);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; bcnt = 0; held = 1'b1; seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) bcnt++;
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout got %0d cycles", tag, lat);
    end
    checks++;
    if (lat != exp_lat(o)) begin
      errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat(o));
    end
    checks++;
    if (bcnt != exp_lat(o)) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, bcnt, exp_lat(o));
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL %s hilo_changed_during_busy got 1 want 0", tag);
    end
    checks++;
    if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h",
               tag, bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done got %b want 0", tag, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL %s done_width got %b want 0", tag, bus.done);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout got none", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_directed();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(2'b00, 32'hFFFF_FFF9, 32'd6, "mult_neg");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(2'b11, 32'd100, 32'd0, "divu_zero");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min");
  endtask

  task automatic test_mt();
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234_5678;
    bus.lo_we = 1'b0;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h0BAD_F00D || bus.lo !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL mt_both got hi=%h lo=%h want 0badf00d", bus.hi, bus.lo);
    end
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mt_single got hi=%h lo=%h want 12345678 9abcdef0",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_mt_priority();
    logic [63:0] exp;
    exp = model(2'b11, 32'd1000, 32'd7);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd1000; bus.rt_val = 32'd7;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mt_with_start got hi=%h lo=%h want 12345678 9abcdef0",
               bus.hi, bus.lo);
    end
    repeat (5) @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_CAFE;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mt_busy got hi=%h lo=%h want 12345678 9abcdef0",
               bus.hi, bus.lo);
    end
    wait_done("mt_busy");
    checks++;
    if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL mt_busy_result got hi=%h lo=%h want hi=%h lo=%h",
               bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    logic [63:0] exp;
    bit extra;
    exp = model(2'b10, 32'hFFFF_FC18, 32'd7);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.rs_val = 32'hFFFF_FC18; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd3; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("start_busy");
    checks++;
    if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL start_busy_result got hi=%h lo=%h want hi=%h lo=%h",
               bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++; $display("FAIL start_busy_queued got 1 want 0");
    end
  endtask

  task automatic test_reset_abort();
    bit any_done;
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd12345; bus.rt_val = 32'd17;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) any_done = 1'b1;
    end
    checks++;
    if (any_done) begin
      errors++; $display("FAIL reset_abort_done got 1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    e1 = model(2'b00, 32'hFFFF_FFFD, 32'd11);
    e2 = model(2'b11, 32'd1_000_003, 32'd97);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'hFFFF_FFFD; bus.rt_val = 32'd11;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_first");
    checks++;
    if (bus.hi !== e1[63:32] || bus.lo !== e1[31:0]) begin
      errors++;
      $display("FAIL b2b_first got hi=%h lo=%h want hi=%h lo=%h",
               bus.hi, bus.lo, e1[63:32], e1[31:0]);
    end
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd1_000_003; bus.rt_val = 32'd97;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy);
    end
    wait_done("b2b_second");
    checks++;
    if (bus.hi !== e2[63:32] || bus.lo !== e2[31:0]) begin
      errors++;
      $display("FAIL b2b_second got hi=%h lo=%h want hi=%h lo=%h",
               bus.hi, bus.lo, e2[63:32], e2[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  o;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(o, a, b, $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00;
    bus.rs_val = '0; bus.rt_val = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    test_reset();
    test_directed();
    test_mt();
    test_mt_priority();
    test_start_busy();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
